// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the data-memory responder
//
// Purpose: request/response structs of the load-FU memory interface and the
// write-buffer entry layout used by the store buffer and the responder top.
// Ports: none (package).

package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        valid;
  } memRespStruct;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wbEntryStruct;

endpackage

// File: rtl/dmem_responder_store_buffer.sv
// rtl/dmem_responder_store_buffer.sv - write buffer with dual enqueue, single drain and forwarding
//
// Purpose: circular FIFO of committed stores. Up to two stores enqueue per
// cycle (lane 0 older than lane 1), one entry drains per cycle, and a lookup
// port returns the youngest buffered store whose word index matches.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   st0_valid_i, st0_entry_i        older incoming store
//   st1_valid_i, st1_entry_i        younger incoming store
//   st_ready_o                      at least two free entries
//   wb_empty_o                      no buffered stores
//   deq_valid_o, deq_entry_o        head entry, drained on this clock edge when valid
//   lookup_idx_i                    word index to search for
//   hit_o, hit_data_o               youngest matching entry found, and its data

module store_buffer
  import dmem_responder_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int IDX_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st0_valid_i,
  input  wbEntryStruct       st0_entry_i,
  input  logic               st1_valid_i,
  input  wbEntryStruct       st1_entry_i,
  output logic               st_ready_o,
  output logic               wb_empty_o,
  output logic               deq_valid_o,
  output wbEntryStruct       deq_entry_o,
  input  logic [IDX_W-1:0]   lookup_idx_i,
  output logic               hit_o,
  output logic [31:0]        hit_data_o
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbEntryStruct      entries_q [WB_DEPTH];
  wbEntryStruct      entries_d [WB_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              enq0, enq1, deq;
  logic [PTR_W-1:0]  scan_ptr;

  // Status is derived from the registered count only, so retire sees a
  // stable ready for the whole cycle.
  assign st_ready_o  = (count_q <= CNT_W'(WB_DEPTH - 2));
  assign wb_empty_o  = (count_q == '0);
  assign deq_valid_o = (count_q != '0);
  assign deq_entry_o = entries_q[head_q];

  assign enq0 = st_ready_o & st0_valid_i;
  assign enq1 = st_ready_o & st1_valid_i;
  assign deq  = deq_valid_o;

  always_comb begin
    entries_d = entries_q;
    if (enq0) begin
      entries_d[tail_q] = st0_entry_i;
    end
    // Lane 1 lands behind lane 0 when both commit, otherwise at the tail.
    if (enq1) begin
      entries_d[enq0 ? tail_q + PTR_W'(1) : tail_q] = st1_entry_i;
    end
    tail_d  = tail_q + PTR_W'(enq0) + PTR_W'(enq1);
    head_d  = head_q + PTR_W'(deq);
    count_d = count_q + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset; count decides which slots are live.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Scan from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    scan_ptr   = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      scan_ptr = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (entries_q[scan_ptr].addr[IDX_W+1:2] == lookup_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[scan_ptr].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder serving loads and draining retired stores
//
// Purpose: word-addressed data array behind the load FU. Loads answer
// combinationally, forwarding from the write buffer; retired stores enter
// the write buffer and drain into the array one per cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   request               load request from the load FU
//   response              load response (same cycle)
//   st0_valid/addr/data   retire lane 0 store (older)
//   st1_valid/addr/data   retire lane 1 store (younger)
//   st_ready              write buffer can take two stores this cycle
//   wb_empty              write buffer fully drained

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int WB_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  memReqStruct  request,
  output memRespStruct response,
  input  logic         st0_valid,
  input  logic [31:0]  st0_addr,
  input  logic [31:0]  st0_data,
  input  logic         st1_valid,
  input  logic [31:0]  st1_addr,
  input  logic [31:0]  st1_data,
  output logic         st_ready,
  output logic         wb_empty
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]       mem_q [MEM_WORDS];

  logic [IDX_W-1:0]  req_idx;
  wbEntryStruct      st0_entry, st1_entry, deq_entry;
  logic              deq_valid;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic              unused_bits;

  // Byte offset is dropped and upper address bits wrap around the array.
  assign req_idx = request.addr[IDX_W+1:2];

  assign st0_entry = '{addr: st0_addr, data: st0_data};
  assign st1_entry = '{addr: st1_addr, data: st1_data};

  assign unused_bits = ^{request.wr_data, request.addr[31:IDX_W+2], request.addr[1:0],
                         deq_entry.addr[31:IDX_W+2], deq_entry.addr[1:0]};

  store_buffer #(
    .WB_DEPTH (WB_DEPTH),
    .IDX_W    (IDX_W)
  ) u_store_buffer (
    .clk          (clk),
    .reset        (reset),
    .st0_valid_i  (st0_valid),
    .st0_entry_i  (st0_entry),
    .st1_valid_i  (st1_valid),
    .st1_entry_i  (st1_entry),
    .st_ready_o   (st_ready),
    .wb_empty_o   (wb_empty),
    .deq_valid_o  (deq_valid),
    .deq_entry_o  (deq_entry),
    .lookup_idx_i (req_idx),
    .hit_o        (fwd_hit),
    .hit_data_o   (fwd_data)
  );

  // Drain writes the array; a reset cycle must not commit the head entry.
  always_ff @(posedge clk) begin
    if (!reset && deq_valid) begin
      mem_q[deq_entry.addr[IDX_W+1:2]] <= deq_entry.data;
    end
  end

  // The head being drained this cycle is still in the buffer, so a
  // concurrent load forwards the same value the array is about to hold.
  always_comb begin
    response = '0;
    if (request.valid && request.MemRead && !reset) begin
      response.valid   = 1'b1;
      response.rd_data = fwd_hit ? fwd_data : mem_q[req_idx];
    end
  end

  // Stores never arrive through the load port, and retire must respect
  // st_ready or the store is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(request.valid && request.MemWrite));
      assert (st_ready || !(st0_valid || st1_valid));
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard testbench for dmem_responder

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  memReqStruct  request;
  memRespStruct response;
  logic         st0_valid, st1_valid;
  logic [31:0]  st0_addr, st0_data, st1_addr, st1_data;
  logic         st_ready, wb_empty;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q [$];
  int          tag_q [$];
  int          load_id = 0;

  dmem_responder #(.MEM_WORDS(1024), .WB_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .response  (response),
    .st0_valid (st0_valid),
    .st0_addr  (st0_addr),
    .st0_data  (st0_data),
    .st1_valid (st1_valid),
    .st1_addr  (st1_addr),
    .st1_data  (st1_data),
    .st_ready  (st_ready),
    .wb_empty  (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid response consumes one expected value.
  always @(negedge clk) begin
    if (response.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_response: got %h expected no response", response.rd_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic int t = tag_q.pop_front();
        check($sformatf("load%0d", t), response.rd_data, e);
      end
    end
  end

  task automatic clear_inputs();
    request   = '0;
    st0_valid = 1'b0; st0_addr = '0; st0_data = '0;
    st1_valid = 1'b0; st1_addr = '0; st1_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [31:0] exp);
    request.valid   = 1'b1;
    request.MemRead = 1'b1;
    request.addr    = addr;
    exp_q.push_back(exp);
    tag_q.push_back(load_id);
    load_id++;
  endtask

  task automatic set_st0(input logic [31:0] a, input logic [31:0] d);
    st0_valid = 1'b1; st0_addr = a; st0_data = d;
  endtask

  task automatic set_st1(input logic [31:0] a, input logic [31:0] d);
    st1_valid = 1'b1; st1_addr = a; st1_data = d;
  endtask

  task automatic drain_all();
    int n = 0;
    while (wb_empty !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(wb_empty), 32'd1);
  endtask

  initial begin
    int sent;
    int cnt_m;
    int n;
    int budget;
    bit saw_block;

    reset = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    // Reset state: status outputs and a load request gated off.
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_wb_empty", 32'(wb_empty), 32'd1);
    request.valid = 1'b1; request.MemRead = 1'b1; request.addr = 32'h10;
    #1;
    check("rst_resp_valid", 32'(response.valid), 32'd0);
    cycle();
    reset = 1'b0;

    // Preload array through the store path.
    set_st0(32'h10, 32'hDEADBEEF);
    set_st1(32'h40, 32'h22222222);
    cycle();
    drain_all();
    set_st0(32'h204, 32'h33330001);
    set_st1(32'h208, 32'h33330002);
    cycle();
    drain_all();
    set_st0(32'h20C, 32'h33330003);
    cycle();
    drain_all();

    // Basic load, then MemRead=0.
    set_load(32'h10, 32'hDEADBEEF);
    cycle();
    request.valid = 1'b1; request.MemRead = 1'b0; request.addr = 32'h10;
    #1;
    check("noread_valid", 32'(response.valid), 32'd0);
    check("noread_data", response.rd_data, 32'd0);
    cycle();

    // Same-cycle store/load sees old value; next cycle forwarded; then array.
    set_st0(32'h40, 32'h11111111);
    set_load(32'h40, 32'h22222222);
    cycle();
    set_load(32'h40, 32'h11111111);
    cycle();
    check("st_drained_empty", 32'(wb_empty), 32'd1);
    set_load(32'h40, 32'h11111111);
    cycle();

    // Two stores to one word in one cycle: younger wins, final value B.
    set_st0(32'h80, 32'h0000000A);
    set_st1(32'h80, 32'h0000000B);
    cycle();
    set_load(32'h80, 32'h0000000B);
    cycle();
    set_load(32'h80, 32'h0000000B);
    cycle();
    check("dup_empty", 32'(wb_empty), 32'd1);
    set_load(32'h80, 32'h0000000B);
    cycle();

    // Fill with 2+2 stores, 10 stores total, tracking occupancy in a model.
    sent = 0; cnt_m = 0; budget = 0; saw_block = 1'b0;
    while (sent < 10 && budget < 100) begin
      check("fill_st_ready", 32'(st_ready), ((4 - cnt_m) >= 2) ? 32'd1 : 32'd0);
      check("fill_wb_empty", 32'(wb_empty), (cnt_m == 0) ? 32'd1 : 32'd0);
      n = 0;
      if ((4 - cnt_m) >= 2) begin
        set_st0(32'h100 + 32'(4 * sent), 32'hC0000000 + 32'(sent));
        sent++; n = 1;
        if (sent < 10) begin
          set_st1(32'h100 + 32'(4 * sent), 32'hC0000000 + 32'(sent));
          sent++; n = 2;
        end
      end else begin
        saw_block = 1'b1;
      end
      cnt_m = cnt_m + n - ((cnt_m > 0) ? 1 : 0);
      cycle();
      budget++;
    end
    check("fill_saw_block", 32'(saw_block), 32'd1);
    drain_all();
    for (int k = 0; k < 10; k++) begin
      set_load(32'h100 + 32'(4 * k), 32'hC0000000 + 32'(k));
      cycle();
    end

    // Aliasing: 0x1004 maps to index 1; 0x43 maps to index 0x10.
    set_st0(32'h1004, 32'h5A5A5A5A);
    cycle();
    set_load(32'h4, 32'h5A5A5A5A);
    cycle();
    drain_all();
    set_load(32'h7, 32'h5A5A5A5A);
    cycle();
    set_load(32'h43, 32'h11111111);
    cycle();

    // Reset with three buffered entries discards them.
    set_st0(32'h200, 32'h70000000);
    set_st1(32'h204, 32'h70000001);
    cycle();
    check("pre_rst_ready", 32'(st_ready), 32'd1);
    set_st0(32'h208, 32'h70000002);
    set_st1(32'h20C, 32'h70000003);
    cycle();
    check("three_buffered_ready", 32'(st_ready), 32'd0);
    reset = 1'b1;
    request.valid = 1'b1; request.MemRead = 1'b1; request.addr = 32'h204;
    #1;
    check("rst_mid_valid", 32'(response.valid), 32'd0);
    cycle();
    check("rst_mid_empty", 32'(wb_empty), 32'd1);
    check("rst_mid_ready", 32'(st_ready), 32'd1);
    reset = 1'b0;
    cycle();
    cycle();
    set_load(32'h200, 32'h70000000);
    cycle();
    set_load(32'h204, 32'h33330001);
    cycle();
    set_load(32'h208, 32'h33330002);
    cycle();
    set_load(32'h20C, 32'h33330003);
    cycle();
    cycle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the other end of the memReqStruct/memRespStruct interface driven by the load FU.
- Serves load requests from the load FU.
- Accepts committed stores from retire (up to two per cycle) into a write buffer, which drains to a word-addressed SRAM array at one store per cycle.
- Loads are forwarded from the write buffer so retired-but-undrained stores are visible.

Parameters:
- MEM_WORDS, 1024, data array depth in 32-bit words (power of 2).
- WB_DEPTH, 4, write-buffer entries (power of 2, >=2).

Ports:
- clk       input   1    clock
- reset     input   1    reset, synchronous, active-high
- request   input   memReqStruct   load request from load FU (addr, wr_data, MemWrite, MemRead, valid)
- response  output  memRespStruct  load response (rd_data, valid)
- st0_valid input   1    retire lane 0 commits a store (older)
- st0_addr  input   32   lane 0 byte address
- st0_data  input   32   lane 0 store data
- st1_valid input   1    retire lane 1 commits a store (younger)
- st1_addr  input   32   lane 1 byte address
- st1_data  input   32   lane 1 store data
- st_ready  output  1    write buffer has >=2 free entries; retire may present stores
- wb_empty  output  1    write buffer empty (used by fence/halt drain)

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Addressing:
  - Word index = addr[log2(MEM_WORDS)+1:2]; addr[1:0] ignored; higher bits wrap modulo MEM_WORDS.
  - Forwarding compares word index only.
- Load path (combinational, zero latency):
  - response.valid = request.valid & request.MemRead & !reset.
  - response.rd_data = youngest valid write-buffer entry with matching index, else mem[index].
  - rd_data = 0 when response.valid = 0.
  - request.MemWrite and request.wr_data are ignored. Assertion: request.valid implies !request.MemWrite.
- Store enqueue (posedge):
  - If st_ready: st0 (when valid) is written at tail, then st1 (when valid) at tail+1, or at tail if st0 not valid.
  - Tail advances by the number enqueued.
- Drain (posedge): if count>0, mem[head.index] <= head.data, head <= head+1.
- Count update:
  - count_next = count + enq - deq (enq 0..2, deq 0..1).
  - Simultaneous enqueue and drain are legal, including enqueue at full-2 while draining.
- Pointers: head/tail are log2(WB_DEPTH) bits and wrap naturally; count is log2(WB_DEPTH)+1 bits.
- Status outputs:
  - st_ready = (WB_DEPTH - count) >= 2, from registered count.
  - wb_empty = (count == 0).
- Store to an already-buffered address: both entries are kept; the younger wins forwarding, and drain order preserves final value.
- Same-cycle store and load to the same address: the load does not see the incoming store; it is visible from the next cycle.
- Drain of head in same cycle as load: the entry is still in the buffer and forwarded, so the result is consistent.
- st*_valid while !st_ready: store dropped. Assertion fires.
- Reset:
  - head = tail = count = 0; buffered stores discarded; st_ready = 1; wb_empty = 1; response.valid = 0.
  - Reset mid-drain discards remaining entries.
  - mem contents are not reset (initialized to 0 at time zero for simulation).

Decomposition:
- typedefs package: keep memReqStruct/memRespStruct; add wbEntryStruct {logic [31:0] addr; logic [31:0] data;}.
- Submodule store_buffer: the FIFO with dual enqueue, single dequeue, and a youngest-match forwarding port (lookup index in, hit + data out).
- dmem_responder: holds the array, the read mux and the assertions.

Test Plan:
- Reset, then load addr 0x10 (mem preloaded 0xDEADBEEF) -> response.valid=1 same cycle, rd_data=0xDEADBEEF; request.MemRead=0 -> valid=0, rd_data=0.
- Store 0x40<-0x11111111 on st0 at cycle t; load 0x40 at t -> old mem value; at t+1 -> 0x11111111 (forwarded); after drain, wb_empty=1 and load still returns 0x11111111.
- Same cycle st0 0x80<-0xA, st1 0x80<-0xB; load 0x80 next cycle -> 0xB; after both drain, mem[0x20]=0xB.
- Fill WB_DEPTH=4 with 2+2 stores in consecutive cycles, no drain stall -> st_ready drops when count>2, recovers after drain; pointers wrap past 3 and data order is correct over 10 stores.
- Address 0x1004 with MEM_WORDS=1024 -> aliases index 1; addr 0x43 -> index 0x10 (low bits ignored).
- Assert reset with 3 buffered entries -> next cycle count=0, st_ready=1, no further mem writes; request.valid with MemWrite=1 -> assertion fails.
